// File: rtl/parity_stream_check.sv
// One-deep registered stage that checks and regenerates parity on a valid/ready
// stream and keeps a saturating count of errored words handed downstream.
module parity_stream_check #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              cfg_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_gen,
    output logic              out_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    logic accept;
    logic deliver;
    logic data_xor;

    // The stage can refill in the same cycle it drains, giving one word per cycle.
    assign in_ready = rst_n & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid & out_ready;
    assign data_xor = ^in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_gen   <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_gen   <= data_xor ^ cfg_odd;
            out_err   <= data_xor ^ in_par ^ cfg_odd;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    // Errors are counted when a word leaves the stage, so a word flushed by reset is never counted.
    always_ff @(posedge clk) begin
        if (!rst_n || err_clr) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (deliver && out_err) begin
            err_sticky <= 1'b1;
            if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_stream_check.sv
// Directed self-checking bench for parity_stream_check; uses a 2-bit counter
// so saturation is reachable with a handful of words.
module tb_parity_stream_check;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              cfg_odd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_gen;
    logic              out_err;
    logic              err_clr;
    logic [CNT_W-1:0]  err_cnt;
    logic              err_sticky;

    int assert_count;
    int fail_count;

    parity_stream_check #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_par     (in_par),
        .cfg_odd    (cfg_odd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_gen    (out_gen),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data, input logic par,
                                 input logic odd, input logic oready, input logic clr);
        in_valid  = valid;
        in_data   = data;
        in_par    = par;
        cfg_odd   = odd;
        out_ready = oready;
        err_clr   = clr;
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_gen", 64'(out_gen), 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
        checkOutput("rst_sticky", 64'(err_sticky), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);

        // Even A5: four ones, so parity bit 0 is correct.
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("first_in_ready", 64'(in_ready), 64'd1);
        step();
        checkOutput("a5_valid", 64'(out_valid), 64'd1);
        checkOutput("a5_data", 64'(out_data), 64'hA5);
        checkOutput("a5_gen", 64'(out_gen), 64'd0);
        checkOutput("a5_err", 64'(out_err), 64'd0);
        checkOutput("a5_cnt", 64'(err_cnt), 64'd0);

        // Even 07: three ones, parity 0 is wrong.
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("e07_valid", 64'(out_valid), 64'd1);
        checkOutput("e07_data", 64'(out_data), 64'h07);
        checkOutput("e07_gen", 64'(out_gen), 64'd1);
        checkOutput("e07_err", 64'(out_err), 64'd1);
        checkOutput("e07_cnt_before", 64'(err_cnt), 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("e07_drained", 64'(out_valid), 64'd0);
        checkOutput("e07_cnt_after", 64'(err_cnt), 64'd1);
        checkOutput("e07_sticky", 64'(err_sticky), 64'd1);

        // Odd 07: parity 0 is correct in odd mode.
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("o07_gen", 64'(out_gen), 64'd0);
        checkOutput("o07_err", 64'(out_err), 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("o07_cnt", 64'(err_cnt), 64'd1);

        // Backpressure: errored 01 held, clean odd-mode 03 waiting.
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_data", 64'(out_data), 64'h01);
            checkOutput("bp_gen", 64'(out_gen), 64'd1);
            checkOutput("bp_err", 64'(out_err), 64'd1);
            checkOutput("bp_cnt", 64'(err_cnt), 64'd1);
        end
        out_ready = 1'b1;
        step();
        checkOutput("bp_w2_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_w2_data", 64'(out_data), 64'h03);
        checkOutput("bp_w2_gen", 64'(out_gen), 64'd1);
        checkOutput("bp_w2_err", 64'(out_err), 64'd0);
        checkOutput("bp_cnt_once", 64'(err_cnt), 64'd2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("bp_w2_drained", 64'(out_valid), 64'd0);
        checkOutput("bp_cnt_final", 64'(err_cnt), 64'd2);

        // Clear, then five errored words back to back.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        checkOutput("clr_cnt", 64'(err_cnt), 64'd0);
        checkOutput("clr_sticky", 64'(err_sticky), 64'd0);
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) in_valid = 1'b0;
            step();
            checkOutput("sat_cnt", 64'(err_cnt), (k > 3) ? 64'd3 : 64'(k));
        end
        checkOutput("sat_sticky", 64'(err_sticky), 64'd1);
        checkOutput("sat_drained", 64'(out_valid), 64'd0);

        // Clear wins over a simultaneous errored handshake.
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        checkOutput("clrhs_cnt", 64'(err_cnt), 64'd0);
        checkOutput("clrhs_sticky", 64'(err_sticky), 64'd0);
        checkOutput("clrhs_valid", 64'(out_valid), 64'd0);
        err_clr = 1'b0;

        // Reset mid-stream with a word held and two errors counted.
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        step();
        checkOutput("mid_cnt", 64'(err_cnt), 64'd2);
        checkOutput("mid_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        step();
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_cnt", 64'(err_cnt), 64'd0);
        checkOutput("mid_rst_data", 64'(out_data), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
        step();
        checkOutput("mid_rst_in_ready2", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("post_valid", 64'(out_valid), 64'd1);
        checkOutput("post_data", 64'(out_data), 64'hA5);
        checkOutput("post_gen", 64'(out_gen), 64'd0);
        checkOutput("post_err", 64'(out_err), 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("post_cnt", 64'(err_cnt), 64'd1);
        checkOutput("post_sticky", 64'(err_sticky), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/parity_stream_check.md
PARITY_STREAM_CHECK -- requirements
Module: parity_stream_check

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: data word width in bits, legal range 1 to 64.
REQ-002 The block SHALL have parameter CNT_W, default 16: error-counter width in bits, minimum 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: data word.
REQ-008 The block SHALL have port in_par, input, 1 bit: received parity bit accompanying in_data.
REQ-009 The block SHALL have port cfg_odd, input, 1 bit: 0 selects even parity, 1 selects odd parity; sampled per word on accept.
REQ-010 The block SHALL have port out_valid, output, 1 bit: output register holds a word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-012 The block SHALL have port out_data, output, DATA_W bits: registered copy of the accepted in_data.
REQ-013 The block SHALL have port out_gen, output, 1 bit: generated parity for out_data under that word's cfg_odd.
REQ-014 The block SHALL have port out_err, output, 1 bit: parity check failed for the held word.
REQ-015 The block SHALL have port err_clr, input, 1 bit: synchronous clear of err_cnt and err_sticky.
REQ-016 The block SHALL have port err_cnt, output, CNT_W bits: saturating count of errored words delivered.
REQ-017 The block SHALL have port err_sticky, output, 1 bit: set by the first errored word delivered, held until cleared.

Function
REQ-018 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-019 in_ready SHALL equal (!out_valid | out_ready) while rst_n=1, and SHALL be 0 while rst_n=0.
REQ-020 Latency SHALL be one cycle: a word accepted at edge N is presented with out_valid=1 after edge N.
REQ-021 On accept, out_gen SHALL be loaded with XOR-reduce(in_data) XOR cfg_odd.
REQ-022 On accept, out_err SHALL be loaded with XOR-reduce(in_data) XOR in_par XOR cfg_odd.
REQ-023 The output handshake SHALL complete on an edge where out_valid and out_ready are both 1.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_gen and out_err SHALL hold stable, and no new word SHALL be accepted.
REQ-025 On a handshake edge with no accept in the same cycle, out_valid SHALL clear to 0.
REQ-026 On a handshake edge with an accept in the same cycle, the new word SHALL load, out_valid SHALL stay 1, and throughput SHALL be one word per cycle.
REQ-027 err_cnt SHALL increment by 1 only on an output handshake with out_err=1.
REQ-028 err_cnt SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-029 err_sticky SHALL set on the same edge as any err_cnt increment condition, including when err_cnt is saturated.
REQ-030 When err_clr=1, err_cnt and err_sticky SHALL be 0 after the edge, overriding a simultaneous increment.
REQ-031 err_clr SHALL NOT affect the data path or the handshake.
REQ-032 A change of cfg_odd SHALL affect only words accepted after the change; the held word SHALL be unaffected.

Reset
REQ-033 When rst_n=0 at a rising edge, the block SHALL drive out_valid=0, out_data=0, out_gen=0, out_err=0, err_cnt=0 and err_sticky=0 after that edge.
REQ-034 A word held when reset is asserted SHALL be discarded, and SHALL NOT be counted.
REQ-035 The first accept SHALL be possible on the first edge with rst_n=1.

Verification
REQ-036 Even mode, send in_data=8'hA5, in_par=0 -> one cycle later out_valid=1, out_gen=0, out_err=0, err_cnt=0.
REQ-037 Even mode, send in_data=8'h07, in_par=0 -> out_gen=1, out_err=1; after the handshake err_cnt=1 and err_sticky=1.
REQ-038 Odd mode, send in_data=8'h07, in_par=0 -> out_gen=0, out_err=0, counter unchanged.
REQ-039 Backpressure: hold out_ready=0 for 3 cycles with an errored word held and a second word pending -> in_ready=0, outputs stable; after release the errored word is counted exactly once and the second word follows back-to-back.
REQ-040 Saturation and clear: CNT_W=2, deliver 5 errored words -> err_cnt=3; assert err_clr on the same edge as another errored handshake -> err_cnt=0 and err_sticky=0.
REQ-041 Reset mid-stream: pull rst_n low while out_valid=1 and err_cnt=2 -> after the edge out_valid=0, err_cnt=0 and in_ready=0 while low; the first word after release is accepted normally.
